mem_dados_bytes: RTL
====================

Name: mem_dados_bytes

Overview:
Parametrised data memory for the single-cycle RISC-V datapath. It is the successor to the word-only data memory.
- Supports byte, halfword and word loads and stores selected by funct3, with sign or zero extension.
- Detects misaligned and out-of-range accesses.
- Clears its contents with a sequential sweep after reset.
- Offers an optional registered read port for the upcoming pipelined core.
It sits between the ALU address output and the write-back mux.

Parameters:
ADDR_W, 8, word-address bits; depth = 2^ADDR_W words of 32 bits.
BASE_ADDR, 32'h10010000, byte address mapped to word 0 (RARS data segment).
READ_LAT, 0, 0 = combinational read; 1 = read data registered (one-cycle latency).

Ports:
iCLK  input  1  clock; all state updates on its rising edge.
iRST  input  1  synchronous active-high reset.
iEnd  input  32  byte address.
iDadoEscrita  input  32  store data; the lane data is in the low bits.
iEscMem  input  1  store request.
iLeMem  input  1  load request.
iFunct3  input  3  access size and sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
oDado  output  32  load result, already extended.
oDebug  output  32  full merged word from the last accepted store.
oBusy  output  1  high while the clear sweep runs.
oErroAlin  output  1  misaligned access flag.
oErroFaixa  output  1  out-of-range access flag.

Behaviour:
- Address decode:
  - off = iEnd - BASE_ADDR (32-bit, wraps).
  - In range iff off < 4*2^ADDR_W.
  - Word index = off[ADDR_W+1:2]; lane = off[1:0].
- Alignment:
  - h/hu: misaligned iff off[0]=1.
  - w: misaligned iff off[1:0]≠0.
  - b/bu: never misaligned.
- Error flags:
  - Both flags are combinational and qualified by (iLeMem | iEscMem).
  - oErroAlin takes priority; if it is set, oErroFaixa is 0.
  - Any funct3 not listed above raises oErroAlin.
- Store (iEscMem=1, no error, oBusy=0): at the clock edge, only the selected lanes are written.
  - sb writes iDadoEscrita[7:0] into lane off[1:0].
  - sh writes iDadoEscrita[15:0] into lanes {off[1],0}+1:0.
  - sw writes the whole word.
  - oDebug <= the resulting merged word, in the same edge.
  - A rejected store changes neither memory nor oDebug.
- Load (iLeMem=1, no error, oBusy=0):
  - Select the lane(s), then extend: b/h sign-extend; bu/hu zero-extend.
  - In every other case the result is 0 (iLeMem=0, any error, busy).
- READ_LAT=0:
  - oDado is combinational from the current inputs.
  - A load and a store to the same word in the same cycle return the pre-write contents.
- READ_LAT=1:
  - oDado is registered; it shows at edge N+1 the result of the request presented in cycle N (read-before-write).
  - Error flags remain combinational.
- Clear sweep, state machine CLEAR → IDLE:
  - iRST=1 at an edge: state <= CLEAR, ptr <= 0, oDebug <= 0, registered oDado <= 0.
  - In CLEAR, each edge writes 0 to word ptr and increments ptr. When ptr = 2^ADDR_W-1 is written, the next state is IDLE.
  - oBusy = (state==CLEAR). It stays high for exactly 2^ADDR_W cycles after iRST is released.
  - iRST asserted during the sweep restarts it at ptr 0.
  - While busy, stores are ignored and loads return 0.
- Power-up: simulation initial state is CLEAR with ptr=0, so memory is zero before first use.

Test Plan:
- ADDR_W=8: write 0xFFFFFFFF to word 3 → pulse iRST for 1 cycle → oBusy high 256 cycles, then low; lw 0x1001000C returns 0; oDebug=0.
- sw 0x10010004 ← 0xDEADBEEF, then loads:
  - lb 0x10010007 → 0xFFFFFFDE
  - lbu 0x10010007 → 0x000000DE
  - lh 0x10010006 → 0xFFFFDEAD
  - lhu 0x10010004 → 0x0000BEEF
  - lw → 0xDEADBEEF
- On that word, sb 0x10010005 ← 0x00000012 → oDebug=0xDEAD12EF, lw 0x10010004 returns 0xDEAD12EF. Then sh 0x10010006 ← 0x0000CAFE → lw returns 0xCAFE12EF.
- sw 0x10010002 ← 0x11111111 → oErroAlin=1, oErroFaixa=0, word unchanged, oDebug unchanged. lh 0x10010003 → oErroAlin=1, oDado=0.
- lw 0x10010400 and lw 0x1000FFFC → oErroFaixa=1, oDado=0. sw 0x10010400 → no memory word changes.
- Reassert iRST when ptr=100 → oBusy stays high 256 further cycles. sw issued during busy is ignored. READ_LAT=1 build: lw 0x10010004 issued in cycle N shows the value on oDado after edge N+1 only; a same-cycle sw to that word returns the old value.

Source files
------------

// File: rtl/mem_dados_bytes_if.sv
// Bus between the datapath and the byte-addressable data memory.
// The master (datapath) drives address, store data, request strobes and
// funct3; the slave (memory) returns the load result, the debug word,
// the busy flag and the two error flags.
interface mem_dados_bytes_if;
   logic [31:0] iEnd;
   logic [31:0] iDadoEscrita;
   logic        iEscMem;
   logic        iLeMem;
   logic [2:0]  iFunct3;
   logic [31:0] oDado;
   logic [31:0] oDebug;
   logic        oBusy;
   logic        oErroAlin;
   logic        oErroFaixa;

   modport master (
      output iEnd, iDadoEscrita, iEscMem, iLeMem, iFunct3,
      input  oDado, oDebug, oBusy, oErroAlin, oErroFaixa
   );

   modport slave (
      input  iEnd, iDadoEscrita, iEscMem, iLeMem, iFunct3,
      output oDado, oDebug, oBusy, oErroAlin, oErroFaixa
   );
endinterface

// File: rtl/mem_dados_bytes.sv
// Byte/halfword/word data memory for the RISC-V datapath.
// Storage is four independent byte-lane arrays so each lane can be written
// on its own. After reset a sweep zeroes every word before the memory
// accepts requests. The read port is combinational (READ_LAT=0) or
// registered with one cycle of latency (READ_LAT=1).
module mem_dados_bytes #(
   parameter int          ADDR_W    = 8,
   parameter logic [31:0] BASE_ADDR = 32'h10010000,
   parameter int          READ_LAT  = 0
) (
   input logic             iCLK,
   input logic             iRST,
   mem_dados_bytes_if.slave bus
);

   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [2:0] F_B  = 3'b000;
   localparam logic [2:0] F_H  = 3'b001;
   localparam logic [2:0] F_W  = 3'b010;
   localparam logic [2:0] F_BU = 3'b100;
   localparam logic [2:0] F_HU = 3'b101;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } stateT;

   // Power-up value: start in the sweep so memory is zero before first use.
   stateT              state = CLEAR;
   stateT              stateNext;
   logic [ADDR_W-1:0]  ptr = '0;
   logic [ADDR_W-1:0]  ptrNext;
   logic               busy;
   logic               clearWe;

   logic [31:0]        off;
   logic               inRange;
   logic [ADDR_W-1:0]  idx;
   logic [1:0]         lane;
   logic               misalign;
   logic               request;
   logic               storeOk;
   logic               loadOk;

   logic [3:0]         byteEn;
   logic [3:0][7:0]    wrByte;
   logic [3:0][7:0]    rdByte;
   logic [3:0][7:0]    mergedWord;
   logic [31:0]        shifted;
   logic [31:0]        extended;
   logic [31:0]        loadVal;
   logic [31:0]        debugReg;

   // ------------------------------------------------------------------
   // Address decode. The offset wraps, so addresses below BASE_ADDR come
   // out huge and fall outside the range check.
   // ------------------------------------------------------------------
   assign off     = bus.iEnd - BASE_ADDR;
   assign inRange = (off >> (ADDR_W + 2)) == 32'd0;
   assign idx     = off[ADDR_W+1:2];
   assign lane    = off[1:0];
   assign request = bus.iLeMem | bus.iEscMem;

   // Alignment check per access size; unknown funct3 counts as misaligned.
   always_comb begin
      misalign = 1'b1;
      case (bus.iFunct3)
         F_B, F_BU: misalign = 1'b0;
         F_H, F_HU: misalign = off[0];
         F_W:       misalign = (off[1:0] != 2'b00);
         default:   misalign = 1'b1;
      endcase
   end

   // Alignment errors mask range errors; both only flag real requests.
   assign bus.oErroAlin  = request & misalign;
   assign bus.oErroFaixa = request & ~misalign & ~inRange;

   assign storeOk = bus.iEscMem & ~misalign & inRange & ~busy;
   assign loadOk  = bus.iLeMem  & ~misalign & inRange & ~busy;

   // ------------------------------------------------------------------
   // Clear sweep FSM
   // ------------------------------------------------------------------

   // State register: reset (re)starts the sweep at word 0.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state <= CLEAR;
         ptr   <= '0;
      end else begin
         state <= stateNext;
         ptr   <= ptrNext;
      end
   end

   // Next state: walk every word once, leave after the last one is zeroed.
   always_comb begin
      stateNext = state;
      ptrNext   = ptr;
      case (state)
         CLEAR: begin
            ptrNext = ptr + 1'b1;
            if (&ptr) begin
               stateNext = IDLE;
            end
         end
         IDLE: begin
            ptrNext = '0;
         end
         default: begin
            stateNext = CLEAR;
            ptrNext   = '0;
         end
      endcase
   end

   // FSM outputs: busy while sweeping, and the sweep owns the write port.
   always_comb begin
      busy    = 1'b0;
      clearWe = 1'b0;
      if (state == CLEAR) begin
         busy    = 1'b1;
         clearWe = 1'b1;
      end
   end

   assign bus.oBusy = busy;

   // ------------------------------------------------------------------
   // Store lane steering: replicate the low data bits across lanes and
   // let the byte enables pick which lanes actually get written.
   // ------------------------------------------------------------------
   // Lane data and enables for the current store size.
   always_comb begin
      byteEn = 4'b0000;
      wrByte = '0;
      case (bus.iFunct3[1:0])
         2'b00: begin
            byteEn = 4'b0001 << lane;
            wrByte = {4{bus.iDadoEscrita[7:0]}};
         end
         2'b01: begin
            byteEn = lane[1] ? 4'b1100 : 4'b0011;
            wrByte = {2{bus.iDadoEscrita[15:0]}};
         end
         2'b10: begin
            byteEn = 4'b1111;
            wrByte = bus.iDadoEscrita;
         end
         default: begin
            byteEn = 4'b0000;
            wrByte = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Storage: one byte-wide array per lane.
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : gLane
         logic [7:0] laneMem [DEPTH];

         // Sweep write has priority; otherwise write this lane if enabled.
         always_ff @(posedge iCLK) begin
            if (clearWe) begin
               laneMem[ptr] <= 8'h00;
            end else if (storeOk && byteEn[gi]) begin
               laneMem[idx] <= wrByte[gi];
            end
         end

         assign rdByte[gi]     = laneMem[idx];
         assign mergedWord[gi] = byteEn[gi] ? wrByte[gi] : rdByte[gi];
      end
   endgenerate

   // Debug word mirrors what the last accepted store left in memory.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         debugReg <= 32'd0;
      end else if (storeOk) begin
         debugReg <= mergedWord;
      end
   end

   assign bus.oDebug = debugReg;

   // ------------------------------------------------------------------
   // Load path: bring the addressed lane down to bit 0, then extend.
   // Reads see the pre-write contents, since the array updates at the edge.
   // ------------------------------------------------------------------
   assign shifted = rdByte >> {lane, 3'b000};

   // Sign or zero extension by access type.
   always_comb begin
      extended = 32'd0;
      case (bus.iFunct3)
         F_B:     extended = {{24{shifted[7]}}, shifted[7:0]};
         F_H:     extended = {{16{shifted[15]}}, shifted[15:0]};
         F_W:     extended = shifted;
         F_BU:    extended = {24'd0, shifted[7:0]};
         F_HU:    extended = {16'd0, shifted[15:0]};
         default: extended = 32'd0;
      endcase
   end

   assign loadVal = loadOk ? extended : 32'd0;

   generate
      if (READ_LAT == 0) begin : gReadComb
         assign bus.oDado = loadVal;
      end else begin : gReadReg
         logic [31:0] dadoReg;

         // One-cycle registered read for the pipelined core.
         always_ff @(posedge iCLK) begin
            if (iRST) begin
               dadoReg <= 32'd0;
            end else begin
               dadoReg <= loadVal;
            end
         end

         assign bus.oDado = dadoReg;
      end
   endgenerate

endmodule
